writeback_scheduler: RTL
========================

// Module: writeback_scheduler
// PURPOSE
// - Shares the single late-writeback path (Forward1Valid/Data/RegAddr) among WBPORTS long-latency units
//   (load, divide, ...). That path feeds the register file write port and the operand forwarding network.
// - Keeps a per-register scoreboard of pending long-latency writes.
// - Stalls issue while any source operand or the destination register is still pending.
// PARAMETERS
// - DATABITWIDTH     16  data word width
// - REGISTERCOUNT    16  number of architectural registers
// - REGADDRBITWIDTH  4   register address width, $clog2(REGISTERCOUNT)
// - WBPORTS          3   number of writeback requesters, 2..8
// PORTS
// - clk               in   1                        clock; all state on posedge
// - sync_rst_n        in   1                        reset, synchronous, active-low
// - clk_en            in   1                        global enable; state frozen when low
// - IssueValid        in   1                        instruction offered for issue this cycle
// - IssueLongLat      in   1                        destination is written later via a WB port
// - IssueDestEn       in   1                        instruction writes a register
// - IssueDestAddr     in   REGADDRBITWIDTH          destination register
// - IssueReadAEn      in   1                        operand A is read
// - IssueReadAAddr    in   REGADDRBITWIDTH          operand A register
// - IssueReadBEn      in   1                        operand B is read
// - IssueReadBAddr    in   REGADDRBITWIDTH          operand B register
// - IssueStall        out  1                        issue blocked this cycle (combinational)
// - WbReqValid        in   WBPORTS                  unit i holds a result
// - WbReqAddr         in   WBPORTS*REGADDRBITWIDTH  destination register per unit, packed
// - WbReqData         in   WBPORTS*DATABITWIDTH     result per unit, packed
// - WbReqReady        out  WBPORTS                  one-hot grant; transfer when Valid&&Ready
// - Forward1Valid     out  1                        registered writeback valid
// - Forward1RegAddr   out  REGADDRBITWIDTH          registered writeback address
// - Forward1Data      out  DATABITWIDTH             registered writeback data
// - PendingAny        out  1                        any scoreboard bit set (drain/flush indicator)
// BEHAVIOUR
// - Reset (sync_rst_n=0 at posedge): scoreboard all 0, RR pointer 0, Forward1Valid/RegAddr/Data all 0.
//   - Reset takes priority over clk_en.
//   - Reset mid-transfer drops the in-flight writeback; units must be reset together with this block.
// - IssueStall = IssueValid && ((ReadAEn && SB[ReadAAddr]) || (ReadBEn && SB[ReadBAddr])
//   || (DestEn && SB[DestAddr])). SB is the current registered value; the same-cycle clear does not bypass.
// - Issue is accepted when IssueValid && !IssueStall && clk_en.
//   - Accepted with LongLat && DestEn: SB[DestAddr] <= 1.
// - Arbitration: round-robin over WbReqValid.
//   - Search starts at pointer; at most one WbReqReady bit per cycle.
//   - Ready is asserted only to a valid requester; all Ready are 0 when clk_en=0 or in reset.
//   - On a grant to unit g, pointer <= (g+1) mod WBPORTS; with no grant, pointer holds.
// - Latency: grant in cycle t gives Forward1Valid=1 in t+1, with Addr/Data of the granted unit.
//   - With no grant at an enabled edge, Forward1Valid <= 0; Addr/Data hold their last value.
// - The grant clears SB[WbReqAddr[g]] at the same edge (end of t).
//   - A consumer stalled in t issues in t+1 and takes Forward1Data via forwarding.
// - Set/clear of the same register on the same edge cannot occur: the WAW check stalls it.
//   - If it arises from a bad requester address, set wins.
// - A writeback to a register whose SB bit is 0 is still forwarded and written; SB is unchanged.
// - clk_en=0: SB, pointer and Forward1* registers hold; IssueStall is still computed.
// - Register 0 is tracked like any other register.
// - PendingAny = |SB (registered SB, combinational OR).
// STRUCTURE
// - Package writeback_pkg: typedef reg_addr_t (logic [REGADDRBITWIDTH-1:0]), typedef sb_vec_t
//   (logic [REGISTERCOUNT-1:0]), localparam RR_PTR_W = $clog2(WBPORTS).
// - Sub-module rr_arbiter #(N): ports clk, sync_rst_n, clk_en, Req[N], Grant[N] one-hot, GrantIdx.
//   - Holds the pointer register.
// - Top level contains the scoreboard vector, the stall compare, the grant mux and the Forward1 output registers.
// TESTING
// - Reset: hold sync_rst_n=0 with all WbReqValid=1 -> Ready=0, Forward1Valid=0, PendingAny=0.
//   - Release -> the first grant goes to unit 0.
// - Load-use: issue LongLat dest r5 in cycle 0; issue read A=r5 in cycle 1 -> IssueStall=1.
//   - Unit1 WbReqValid in cycle 3 with Addr=5, Data=16'hBEEF -> Ready[1]=1 in cycle 3.
//   - Cycle 4: Forward1Valid=1, Addr=5, Data=BEEF, IssueStall=0.
// - Round-robin: all 3 units valid continuously -> grants 0,1,2,0,1,2 on consecutive cycles.
//   - Drop unit 1 -> grants 0,2,0,2.
// - WAW: r7 pending, issue DestEn r7 non-LongLat -> stall until the r7 writeback grant.
//   - Issue in the cycle after that grant -> accepted.
// - clk_en=0 for 3 cycles with requests and issue pending -> no Ready, SB/pointer/Forward1 unchanged.
//   - Resumes with the same next grant.
// - Two pending registers r2 and r9 written back in one burst -> PendingAny falls only after both grant edges.

Source files
------------

// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_pkg
//  Description : Shared widths, types and helpers for the writeback scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_pkg;

    localparam int DATABITWIDTH    = 16;
    localparam int REGISTERCOUNT   = 16;
    localparam int REGADDRBITWIDTH = $clog2(REGISTERCOUNT);
    localparam int WBPORTS         = 3;
    localparam int RR_PTR_W        = $clog2(WBPORTS);

    typedef logic [REGADDRBITWIDTH-1:0] reg_addr_t;
    typedef logic [REGISTERCOUNT-1:0]   sb_vec_t;
    typedef logic [DATABITWIDTH-1:0]    data_t;

    function automatic sb_vec_t regDecode(input reg_addr_t addr);
        return sb_vec_t'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_scheduler_if
//  Description : Issue, writeback-request and forwarding bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_scheduler_if;
    import writeback_pkg::*;

    logic                                IssueValid;
    logic                                IssueLongLat;
    logic                                IssueDestEn;
    reg_addr_t                           IssueDestAddr;
    logic                                IssueReadAEn;
    reg_addr_t                           IssueReadAAddr;
    logic                                IssueReadBEn;
    reg_addr_t                           IssueReadBAddr;
    logic                                IssueStall;

    logic [WBPORTS-1:0]                  WbReqValid;
    logic [WBPORTS*REGADDRBITWIDTH-1:0]  WbReqAddr;
    logic [WBPORTS*DATABITWIDTH-1:0]     WbReqData;
    logic [WBPORTS-1:0]                  WbReqReady;

    logic                                Forward1Valid;
    reg_addr_t                           Forward1RegAddr;
    data_t                               Forward1Data;
    logic                                PendingAny;

    // Pipeline / execution units side
    modport master (
        output IssueValid, IssueLongLat, IssueDestEn, IssueDestAddr,
        output IssueReadAEn, IssueReadAAddr, IssueReadBEn, IssueReadBAddr,
        output WbReqValid, WbReqAddr, WbReqData,
        input  IssueStall, WbReqReady, Forward1Valid, Forward1RegAddr, Forward1Data, PendingAny
    );

    // Scheduler side
    modport slave (
        input  IssueValid, IssueLongLat, IssueDestEn, IssueDestAddr,
        input  IssueReadAEn, IssueReadAAddr, IssueReadBEn, IssueReadBAddr,
        input  WbReqValid, WbReqAddr, WbReqData,
        output IssueStall, WbReqReady, Forward1Valid, Forward1RegAddr, Forward1Data, PendingAny
    );

endinterface
`default_nettype wire

// File: rtl/writeback_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot arbiter; search starts at the pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             clk_en,
    input  logic [N-1:0]     Req,
    output logic [N-1:0]     Grant,
    output logic [PTR_W-1:0] GrantIdx
);

    logic [PTR_W-1:0] r_ptr;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_reqHi;
    logic             w_found;
    logic             w_active;

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    always_comb begin
        w_mask   = '0;
        GrantIdx = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_mask[k] = (PTR_W'(k) >= r_ptr);
        end
        w_reqHi = Req & w_mask;
        for (int k = N - 1; k >= 0; k--) begin
            if (Req[k]) begin
                GrantIdx = PTR_W'(k);
                w_found  = 1'b1;
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (w_reqHi[k]) begin
                GrantIdx = PTR_W'(k);
            end
        end
        w_active = w_found && clk_en && sync_rst_n;
        Grant    = w_active ? (N'(1) << GrantIdx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_ptr <= '0;
        end else if (w_active) begin
            r_ptr <= (GrantIdx == PTR_W'(N - 1)) ? '0 : GrantIdx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_scheduler
//  Description : Shares the late-writeback path among long-latency units and
//                stalls issue on pending source/destination registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_scheduler
    import writeback_pkg::*;
(
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  clk_en,
    writeback_scheduler_if.slave  bus
);

    logic [WBPORTS-1:0]  w_grant;
    logic [RR_PTR_W-1:0] w_grantIdx;
    logic                w_anyGrant;
    reg_addr_t           w_wbAddr;
    data_t               w_wbData;
    logic                w_stall;
    logic                w_issueAccept;
    sb_vec_t             w_setVec;
    sb_vec_t             w_clrVec;

    sb_vec_t             r_sb;
    logic                r_fwdValid;
    reg_addr_t           r_fwdAddr;
    data_t               r_fwdData;

    rr_arbiter #(
        .N (WBPORTS)
    ) u_arbiter (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clk_en     (clk_en),
        .Req        (bus.WbReqValid),
        .Grant      (w_grant),
        .GrantIdx   (w_grantIdx)
    );

    assign w_anyGrant = |w_grant;

    always_comb begin
        w_wbAddr = '0;
        w_wbData = '0;
        for (int g = 0; g < WBPORTS; g++) begin
            if (w_grantIdx == RR_PTR_W'(g)) begin
                w_wbAddr = bus.WbReqAddr[g*REGADDRBITWIDTH +: REGADDRBITWIDTH];
                w_wbData = bus.WbReqData[g*DATABITWIDTH +: DATABITWIDTH];
            end
        end
    end

    // Stall uses the registered scoreboard only; a clear landing this edge is seen next cycle.
    assign w_stall = bus.IssueValid &&
                     ((bus.IssueReadAEn && r_sb[bus.IssueReadAAddr]) ||
                      (bus.IssueReadBEn && r_sb[bus.IssueReadBAddr]) ||
                      (bus.IssueDestEn  && r_sb[bus.IssueDestAddr]));

    assign w_issueAccept = bus.IssueValid && !w_stall && clk_en;
    assign w_setVec      = (w_issueAccept && bus.IssueLongLat && bus.IssueDestEn)
                           ? regDecode(bus.IssueDestAddr) : '0;
    assign w_clrVec      = w_anyGrant ? regDecode(w_wbAddr) : '0;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_sb       <= '0;
            r_fwdValid <= 1'b0;
            r_fwdAddr  <= '0;
            r_fwdData  <= '0;
        end else if (clk_en) begin
            // Set wins over clear so a bad requester address cannot lose a pending write.
            r_sb       <= (r_sb & ~w_clrVec) | w_setVec;
            r_fwdValid <= w_anyGrant;
            if (w_anyGrant) begin
                r_fwdAddr <= w_wbAddr;
                r_fwdData <= w_wbData;
            end
        end
    end

    assign bus.IssueStall      = w_stall;
    assign bus.WbReqReady      = w_grant;
    assign bus.Forward1Valid   = r_fwdValid;
    assign bus.Forward1RegAddr = r_fwdAddr;
    assign bus.Forward1Data    = r_fwdData;
    assign bus.PendingAny      = |r_sb;

endmodule
`default_nettype wire
